// File: rtl/directory_out_queue.sv
// Per-destination request FIFO sitting behind the directory request generator.
// Buffers operation/address/line-data triples and hands them to the consumer over valid/ready.
module directory_out_queue #(
   parameter int CL_SIZE   = 128,
   parameter int ADDR_W    = 32,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_flush,
   input  logic                       i_alloc,
   input  logic [2:0]                 i_operation,
   input  logic [ADDR_W-1:0]          i_addr,
   input  logic [CL_SIZE-1:0]         i_data,
   output logic                       o_full,
   output logic                       o_almost_full,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [2:0]                 o_out_operation,
   output logic [ADDR_W-1:0]          o_out_addr,
   output logic [CL_SIZE-1:0]         o_out_data,
   output logic                       o_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [2:0] OP_NOOP = 3'd0;

   logic [2:0]         r_memOp   [DEPTH];
   logic [ADDR_W-1:0]  r_memAddr [DEPTH];
   logic [CL_SIZE-1:0] r_memData [DEPTH];

   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_wrPtr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   logic          w_full;
   logic          w_valid;
   logic          w_isOp;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [CW-1:0] w_countNext;

   // Status flags come only from the count register so the directory never sees an input-to-output path.
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_valid = (r_count != '0);
   assign w_isOp  = i_alloc && (i_operation != OP_NOOP);

   // Flush wins over everything in the same cycle, so both handshakes are masked by it.
   assign w_pop       = w_valid && i_out_ready && !i_flush;
   assign w_push      = w_isOp && (!w_full || w_pop) && !i_flush;
   assign w_drop      = w_isOp && w_full && !w_pop && !i_flush;
   assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdPtr    <= '0;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_flush) begin
         r_rdPtr    <= '0;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         r_count <= w_countNext;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage needs no reset; the head is masked while the queue is empty.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_memOp[r_wrPtr]   <= i_operation;
         r_memAddr[r_wrPtr] <= i_addr;
         r_memData[r_wrPtr] <= i_data;
      end
   end

   assign o_full          = w_full;
   assign o_almost_full   = (r_count >= CW'(AF_THRESH));
   assign o_count         = r_count;
   assign o_out_valid     = w_valid;
   assign o_overflow      = r_overflow;
   assign o_out_operation = w_valid ? r_memOp[r_rdPtr]   : '0;
   assign o_out_addr      = w_valid ? r_memAddr[r_rdPtr] : '0;
   assign o_out_data      = w_valid ? r_memData[r_rdPtr] : '0;

endmodule

// File: tb/tb_directory_out_queue.sv
// Self-checking bench for directory_out_queue: scenario tasks plus a scoreboard
// monitor that checks every entry the consumer accepts against the expected order.
module tb_directory_out_queue;

   typedef struct packed {
      logic [2:0]   op;
      logic [31:0]  addr;
      logic [127:0] data;
   } entry_t;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         alloc;
   logic [2:0]   operation;
   logic [31:0]  addr;
   logic [127:0] data;
   logic         full;
   logic         almostFull;
   logic [2:0]   count;
   logic         outValid;
   logic         outReady;
   logic [2:0]   outOperation;
   logic [31:0]  outAddr;
   logic [127:0] outData;
   logic         overflow;

   int     testsRun;
   int     testsFailed;
   entry_t sbQ[$];

   directory_out_queue #(
      .CL_SIZE(128), .ADDR_W(32), .DEPTH(4), .AF_THRESH(3)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_alloc(alloc),
      .i_operation(operation), .i_addr(addr), .i_data(data),
      .o_full(full), .o_almost_full(almostFull), .o_count(count),
      .o_out_valid(outValid), .i_out_ready(outReady),
      .o_out_operation(outOperation), .o_out_addr(outAddr),
      .o_out_data(outData), .o_overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: at the falling edge, a valid&&ready head will be consumed at the next rising edge.
   always @(negedge clk) begin
      entry_t exp;
      if (!rst && !flush && outValid && outReady) begin
         testsRun++;
         if (sbQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL sb_unexpected_pop: got op=%0d addr=%h, expected no entry", outOperation, outAddr);
         end else begin
            exp = sbQ.pop_front();
            if ({outOperation, outAddr, outData} !== {exp.op, exp.addr, exp.data}) begin
               testsFailed++;
               $display("[TB] FAIL sb_head: got op=%0d addr=%h data=%h, expected op=%0d addr=%h data=%h",
                        outOperation, outAddr, outData, exp.op, exp.addr, exp.data);
            end
         end
      end
   end

   // One clock of stimulus; inputs return to idle 1ns after the edge.
   task automatic applyStimulus(input logic a, input logic [2:0] op, input logic [31:0] ad,
                                input logic [127:0] d, input logic rdy, input logic fl);
      alloc = a; operation = op; addr = ad; data = d; outReady = rdy; flush = fl;
      @(posedge clk);
      #1;
      alloc = 1'b0; operation = 3'd0; addr = '0; data = '0; outReady = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      testsRun++;
      if ({outValid, full, almostFull, overflow, count} !== 7'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got valid=%b full=%b af=%b ovf=%b count=%0d, expected all 0",
                  outValid, full, almostFull, overflow, count);
      end
      testsRun++;
      if ({outOperation, outAddr, outData} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_head: got op=%0d addr=%h data=%h, expected 0", outOperation, outAddr, outData);
      end
      rst = 1'b0;
   endtask

   task automatic test_first_push();
      entry_t e;
      e = '{op: 3'd3, addr: 32'h40, data: {$urandom(), $urandom(), $urandom(), $urandom()}};
      alloc = 1'b1; operation = e.op; addr = e.addr; data = e.data;
      testsRun++;
      if (outValid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL first_valid_same_cycle: got %b expected 0", outValid);
      end
      sbQ.push_back(e);
      applyStimulus(1'b1, e.op, e.addr, e.data, 1'b0, 1'b0);
      testsRun++;
      if ({outValid, outOperation, outAddr, count} !== {1'b1, 3'd3, 32'h40, 3'd1}) begin
         testsFailed++;
         $display("[TB] FAIL first_next_cycle: got valid=%b op=%0d addr=%h count=%0d, expected 1 3 40 1",
                  outValid, outOperation, outAddr, count);
      end
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
      testsRun++;
      if ({outValid, count} !== {1'b0, 3'd0}) begin
         testsFailed++;
         $display("[TB] FAIL first_drained: got valid=%b count=%0d, expected 0 0", outValid, count);
      end
   endtask

   task automatic test_fill_overflow();
      entry_t e;
      for (int i = 0; i < 4; i++) begin
         testsRun++;
         if (almostFull !== (i >= 3)) begin
            testsFailed++;
            $display("[TB] FAIL fill_almost_full_%0d: got %b expected %b", i, almostFull, (i >= 3));
         end
         e = '{op: 3'(3 + (i % 5)), addr: 32'h200 + 32'(i), data: {$urandom(), $urandom(), $urandom(), $urandom()}};
         if (e.op == 3'd0) e.op = 3'd2;
         sbQ.push_back(e);
         applyStimulus(1'b1, e.op, e.addr, e.data, 1'b0, 1'b0);
      end
      testsRun++;
      if ({full, almostFull, overflow, count} !== {1'b1, 1'b1, 1'b0, 3'd4}) begin
         testsFailed++;
         $display("[TB] FAIL fill_full: got full=%b af=%b ovf=%b count=%0d, expected 1 1 0 4",
                  full, almostFull, overflow, count);
      end
      applyStimulus(1'b1, 3'd5, 32'h999, '1, 1'b0, 1'b0);
      testsRun++;
      if ({overflow, count} !== {1'b1, 3'd4}) begin
         testsFailed++;
         $display("[TB] FAIL fill_overflow: got ovf=%b count=%0d, expected 1 4", overflow, count);
      end
      repeat (4) applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
      testsRun++;
      if ({outValid, count, overflow} !== {1'b0, 3'd0, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL fill_drain_sticky: got valid=%b count=%0d ovf=%b, expected 0 0 1", outValid, count, overflow);
      end
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
      testsRun++;
      if (overflow !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL fill_flush_clears_ovf: got %b expected 0", overflow);
      end
   endtask

   task automatic test_full_push_pop();
      entry_t e;
      for (int i = 0; i < 4; i++) begin
         e = '{op: 3'd3, addr: 32'h300 + 32'(i), data: {4{$urandom()}}};
         sbQ.push_back(e);
         applyStimulus(1'b1, e.op, e.addr, e.data, 1'b0, 1'b0);
      end
      e = '{op: 3'd4, addr: 32'h3A5, data: {16{8'hA5}}};
      sbQ.push_back(e);
      applyStimulus(1'b1, e.op, e.addr, e.data, 1'b1, 1'b0);
      testsRun++;
      if ({count, overflow, full} !== {3'd4, 1'b0, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL full_push_pop: got count=%0d ovf=%b full=%b, expected 4 0 1", count, overflow, full);
      end
      repeat (3) applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
      testsRun++;
      if ({count, outOperation, outData} !== {3'd1, 3'd4, {16{8'hA5}}}) begin
         testsFailed++;
         $display("[TB] FAIL full_new_last: got count=%0d op=%0d data=%h, expected 1 4 a5..a5", count, outOperation, outData);
      end
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_noop();
      applyStimulus(1'b1, 3'd0, 32'h55, {4{32'hDEADBEEF}}, 1'b1, 1'b0);
      testsRun++;
      if ({count, outValid, overflow} !== {3'd0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL noop_ignored: got count=%0d valid=%b ovf=%b, expected 0 0 0", count, outValid, overflow);
      end
   endtask

   task automatic test_wrap();
      entry_t e;
      int maxCount;
      maxCount = 0;
      for (int i = 0; i < 10; i++) begin
         e = '{op: (i % 2) ? 3'd3 : 3'd6, addr: 32'h100 + 32'(i), data: {4{$urandom()}}};
         sbQ.push_back(e);
         applyStimulus(1'b1, e.op, e.addr, e.data, (i != 0), 1'b0);
         if (int'(count) > maxCount) maxCount = int'(count);
      end
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
      testsRun++;
      if (maxCount != 1) begin
         testsFailed++;
         $display("[TB] FAIL wrap_max_count: got %0d expected 1", maxCount);
      end
      testsRun++;
      if ({count, outValid} !== {3'd0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL wrap_empty: got count=%0d valid=%b, expected 0 0", count, outValid);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 3'd7, 32'h700 + 32'(i), {4{$urandom()}}, 1'b0, 1'b0);
      end
      testsRun++;
      if (count !== 3'd3) begin
         testsFailed++;
         $display("[TB] FAIL flush_prefill: got count=%0d expected 3", count);
      end
      applyStimulus(1'b1, 3'd3, 32'h777, '1, 1'b0, 1'b1);
      testsRun++;
      if ({count, outValid, overflow} !== {3'd0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL flush_priority: got count=%0d valid=%b ovf=%b, expected 0 0 0", count, outValid, overflow);
      end
   endtask

   task automatic test_async_reset();
      applyStimulus(1'b1, 3'd3, 32'h800, '1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd4, 32'h804, '1, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      testsRun++;
      if ({outValid, full, almostFull, overflow, count, outOperation, outAddr} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL async_reset: got valid=%b count=%0d op=%0d addr=%h, expected all 0",
                  outValid, count, outOperation, outAddr);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
      testsRun++;
      if ({outValid, count} !== {1'b0, 3'd0}) begin
         testsFailed++;
         $display("[TB] FAIL async_reset_after: got valid=%b count=%0d, expected 0 0", outValid, count);
      end
   endtask

   task automatic checkOutput();
      testsRun++;
      if (sbQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL sb_leftover: got %0d undelivered entries, expected 0", sbQ.size());
      end
   endtask

   initial begin
      testsRun = 0;
      testsFailed = 0;
      rst = 1'b1; flush = 1'b0; alloc = 1'b0; operation = '0; addr = '0; data = '0; outReady = 1'b0;
      test_reset();
      test_first_push();
      test_fill_overflow();
      test_full_push_pop();
      test_noop();
      test_wrap();
      test_flush();
      test_async_reset();
      checkOutput();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
